// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared types and constants for the counter sequencer.
// Sequencer state encoding, counter data width and direction codes.
package cnt_seq_pkg;

  localparam int   CNT_W  = 8;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESET = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/cnt_seq_rr_arb.sv
// cnt_seq_rr_arb: combinational round-robin pick of the first request at or after ptr.
// Ports: req (requests), ptr (start index) -> win (one-hot), win_idx (index), any (some request).
module cnt_seq_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      win_idx,
  output logic               any
);

  always_comb begin
    int j;
    win     = '0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (win == '0 && req[IW'(j)]) begin
        win[IW'(j)] = 1'b1;
        win_idx     = IW'(j);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/updown_counter_sequencer.sv
// updown_counter_sequencer: shares one up/down expiry counter among NUM_REQ requesters.
// Ports: clk, reset (sync, active-high); req_valid/req_dir/req_value/req_pause in;
//   grant, done, err, busy out; new_cntr_preset(_value), enable_cnt_up/dn,
//   pause_counting to the counter; ctr_expired from it.
// Build option: define CNT_SEQ_TIMEOUT_EN to end RUN with err=1 after TIMEOUT_CYC cycles.
module updown_counter_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PRESET_HOLD = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*CNT_W-1:0] req_value,
  input  logic [NUM_REQ-1:0]       req_pause,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic                     new_cntr_preset,
  output logic [CNT_W-1:0]         new_cntr_preset_value,
  output logic                     enable_cnt_up,
  output logic                     enable_cnt_dn,
  output logic                     pause_counting,
  input  logic                     ctr_expired
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // One phase counter serves PRESET, SETTLE and (optionally) RUN.
  localparam int MAX_HS =
    (PRESET_HOLD > SETTLE_CYC) ? PRESET_HOLD : SETTLE_CYC;
  localparam int MAX_C =
    (MAX_HS > TIMEOUT_CYC) ? MAX_HS : TIMEOUT_CYC;
  localparam int CW = $clog2(MAX_C + 1);

  state_e               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        ptr;
  logic                 dir;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   win;
  logic [IW-1:0]        win_idx;
  logic                 any;
  logic                 timeout;

  cnt_seq_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

`ifdef CNT_SEQ_TIMEOUT_EN
  assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Pause is a live pass-through of the owner's request, gated to RUN.
  assign pause_counting = (state == RUN) & req_pause[owner];

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      owner                 <= '0;
      ptr                   <= '0;
      dir                   <= DIR_DN;
      cnt                   <= '0;
      grant                 <= '0;
      done                  <= '0;
      err                   <= 1'b0;
      busy                  <= 1'b0;
      new_cntr_preset       <= 1'b0;
      new_cntr_preset_value <= '0;
      enable_cnt_up         <= 1'b0;
      enable_cnt_dn         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state           <= PRESET;
            owner           <= win_idx;
            dir             <= req_dir[win_idx];
            grant           <= win;
            busy            <= 1'b1;
            new_cntr_preset <= 1'b1;
            new_cntr_preset_value <=
              req_value[int'(win_idx)*CNT_W +: CNT_W];
            cnt             <= '0;
          end
        end
        PRESET: begin
          if (cnt == CW'(PRESET_HOLD - 1)) begin
            state           <= SETTLE;
            new_cntr_preset <= 1'b0;
            cnt             <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            state         <= RUN;
            enable_cnt_up <= (dir == DIR_UP);
            enable_cnt_dn <= (dir == DIR_DN);
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (ctr_expired || timeout) begin
            state         <= DONE;
            enable_cnt_up <= 1'b0;
            enable_cnt_dn <= 1'b0;
            done          <= grant;
            // A real expiry beats a coincident timeout.
            err           <= timeout & ~ctr_expired;
          end else begin
`ifdef CNT_SEQ_TIMEOUT_EN
            cnt <= cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
          err   <= 1'b0;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// tb_updown_counter_sequencer: directed plus random checks of the sequencer
// against a cycle-indexed behavioural model of each operation.
module tb_updown_counter_sequencer;

  localparam int N  = 4;
  localparam int PH = 2;
  localparam int SC = 2;
  localparam int TO = 16;
`ifdef CNT_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_dir, req_pause;
  logic [N*8-1:0] req_value;
  logic           ctr_expired;
  logic [N-1:0]   grant, done;
  logic           err, busy, new_cntr_preset;
  logic [7:0]     new_cntr_preset_value;
  logic           enable_cnt_up, enable_cnt_dn, pause_counting;

  updown_counter_sequencer #(
    .NUM_REQ     (N),
    .PRESET_HOLD (PH),
    .SETTLE_CYC  (SC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_dir               (req_dir),
    .req_value             (req_value),
    .req_pause             (req_pause),
    .grant                 (grant),
    .done                  (done),
    .err                   (err),
    .busy                  (busy),
    .new_cntr_preset       (new_cntr_preset),
    .new_cntr_preset_value (new_cntr_preset_value),
    .enable_cnt_up         (enable_cnt_up),
    .enable_cnt_dn         (enable_cnt_dn),
    .pause_counting        (pause_counting),
    .ctr_expired           (ctr_expired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: one operation at a time, tracked by cycle index since grant.
  bit         m_act, m_done, m_err, m_dir;
  int         m_owner, m_ptr, m_k;
  logic [7:0] m_val;

  int         order[$];
  int         exp_ord[5] = '{0, 1, 2, 3, 0};
  int         ndone, gotc;
  logic       errv;
  logic [N-1:0] pg;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_run();
    return m_act && !m_done && (m_k > PH + SC);
  endfunction

  task automatic model_step();
    int j;
    bit found;
    if (reset) begin
      m_act = 0; m_done = 0; m_err = 0; m_dir = 0;
      m_owner = 0; m_ptr = 0; m_k = 0; m_val = '0;
    end else if (!m_act) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        j = (m_ptr + i) % N;
        if (!found && req_valid[j]) begin
          found   = 1;
          m_act   = 1;
          m_owner = j;
          m_dir   = req_dir[j];
          m_val   = req_value[j*8 +: 8];
          m_k     = 1;
        end
      end
    end else if (m_done) begin
      m_act  = 0;
      m_done = 0;
      m_err  = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (m_k > PH + SC) begin
      if (ctr_expired) begin
        m_done = 1; m_err = 0;
      end else if (TO_EN && (m_k - PH - SC) == TO) begin
        m_done = 1; m_err = 1;
      end else begin
        m_k++;
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] oh;
    bit run;
    oh = '0;
    if (m_act) oh[m_owner] = 1'b1;
    run = m_run();
    chk("grant", 32'(grant), 32'(oh));
    chk("done", 32'(done), m_done ? 32'(oh) : 32'd0);
    chk("err", 32'(err), 32'(m_done & m_err));
    chk("busy", 32'(busy), 32'(m_act));
    chk("preset", 32'(new_cntr_preset),
        32'(m_act && !m_done && m_k <= PH));
    chk("preset_value", 32'(new_cntr_preset_value), 32'(m_val));
    chk("en_up", 32'(enable_cnt_up), 32'(run && m_dir));
    chk("en_dn", 32'(enable_cnt_dn), 32'(run && !m_dir));
    chk("pause", 32'(pause_counting),
        32'(run && req_pause[m_owner]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_dir = '0; req_pause = '0;
    req_value = '0; ctr_expired = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_preset", 32'(new_cntr_preset), 32'd0);
    chk("rst_en", 32'({enable_cnt_up, enable_cnt_dn}), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: single up-count, value 5, literal timeline.
    do_reset();
    req_valid = 4'b0001; req_dir = 4'b0001; req_value[7:0] = 8'd5;
    tick();
    chk("t1_grant_c1", 32'(grant), 32'h1);
    chk("t1_preset_c1", 32'(new_cntr_preset), 32'd1);
    chk("t1_val_c1", 32'(new_cntr_preset_value), 32'd5);
    tick();
    chk("t1_preset_c2", 32'(new_cntr_preset), 32'd1);
    tick();
    chk("t1_preset_c3", 32'(new_cntr_preset), 32'd0);
    tick();
    chk("t1_up_c4", 32'(enable_cnt_up), 32'd0);
    tick();
    chk("t1_up_c5", 32'(enable_cnt_up), 32'd1);
    repeat (7) tick();
    ctr_expired = 1'b1;
    tick();
    chk("t1_done_c13", 32'(done), 32'h1);
    chk("t1_err_c13", 32'(err), 32'd0);
    ctr_expired = 1'b0; req_valid = '0;
    tick();
    chk("t1_busy_c14", 32'(busy), 32'd0);

    // Test 2: all requesting, round-robin order.
    do_reset();
    req_valid = '1;
    req_dir   = 4'($urandom);
    req_value = $urandom;
    ndone = 0; pg = '0;
    for (int c = 0; c < 600 && order.size() < 5; c++) begin
      ctr_expired = ($urandom_range(0, 3) == 0);
      tick();
      if (grant != '0 && pg == '0)
        for (int i = 0; i < N; i++)
          if (grant[i]) order.push_back(i);
      if (done != '0) ndone++;
      pg = grant;
    end
    chk("t2_ngrants", 32'(order.size()), 32'd5);
    while (order.size() < 5) order.push_back(-1);
    for (int i = 0; i < 5; i++)
      chk("t2_order", 32'(order[i]), 32'(exp_ord[i]));
    chk("t2_dones", 32'(ndone), 32'd4);
    req_valid = '0; ctr_expired = 1'b1;
    repeat (12) tick();
    ctr_expired = 1'b0;
    tick();

    // Test 3: down count with toggling pause.
    do_reset();
    req_valid = 4'b0010; req_dir = '0;
    req_value[15:8] = 8'd10; req_pause = '1;
    tick();
    chk("t3_pause_preset", 32'(pause_counting), 32'd0);
    tick(); tick();
    chk("t3_pause_settle", 32'(pause_counting), 32'd0);
    tick(); tick();
    chk("t3_pause_run", 32'(pause_counting), 32'd1);
    chk("t3_en_dn", 32'(enable_cnt_dn), 32'd1);
    chk("t3_en_up", 32'(enable_cnt_up), 32'd0);
    for (int c = 6; c < 20; c++) begin
      req_pause = 4'($urandom);
      req_pause[1] = c[0];
      tick();
    end
    req_pause = '1; ctr_expired = 1'b1;
    tick();
    chk("t3_done", 32'(done), 32'h2);
    chk("t3_pause_done", 32'(pause_counting), 32'd0);
    ctr_expired = 1'b0; req_valid = '0; req_pause = '0;
    tick();

    // Test 4: stale expiry in SETTLE, value 0.
    do_reset();
    req_valid = 4'b0100; req_dir = 4'b0100;
    req_value[23:16] = 8'd0;
    tick();
    chk("t4_grant", 32'(grant), 32'h4);
    chk("t4_val0", 32'(new_cntr_preset_value), 32'd0);
    tick(); tick();
    ctr_expired = 1'b1;
    tick();
    ctr_expired = 1'b0;
    tick();
    chk("t4_run", 32'(enable_cnt_up), 32'd1);
    chk("t4_nodone", 32'(done), 32'd0);
    tick(); tick(); tick();
    ctr_expired = 1'b1;
    tick();
    chk("t4_done_c9", 32'(done), 32'h4);
    ctr_expired = 1'b0; req_valid = '0;
    tick();

    // Test 5: no expiry; timeout or endless RUN.
    req_valid = 4'b1000; req_dir = '0; req_value[31:24] = 8'hff;
    gotc = -1; errv = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (done != '0 && gotc < 0) begin
        gotc = c;
        errv = err;
      end
    end
`ifdef CNT_SEQ_TIMEOUT_EN
    chk("t5_to_cycle", 32'(gotc), 32'(1 + PH + SC + TO));
    chk("t5_to_err", 32'(errv), 32'd1);
`else
    chk("t5_no_done", 32'(gotc), 32'hffffffff);
    chk("t5_still_run", 32'(enable_cnt_dn), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
`endif

    // Test 6: reset in RUN, pointer back to 0.
    for (int c = 0; c < 60 && !m_run(); c++) tick();
    chk("t6_in_run", 32'(m_run()), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_grant0", 32'(grant), 32'd0);
    chk("t6_en", 32'({enable_cnt_up, enable_cnt_dn}), 32'd0);
    reset = 1'b0; req_valid = 4'b1001;
    tick();
    chk("t6_grant", 32'(grant), 32'h1);
    req_valid = '0; ctr_expired = 1'b1;
    repeat (8) tick();
    ctr_expired = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid   = 4'($urandom);
      req_dir     = 4'($urandom);
      req_pause   = 4'($urandom);
      req_value   = $urandom;
      ctr_expired = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
